updn_counter: RTL and testbench

UPDN_COUNTER -- requirements
Module: updn_counter

---
 rtl/updn_counter_pkg.sv | 20 ++
 rtl/updn_counter_next.sv | 113 +++++++++++
 rtl/updn_counter.sv | 83 ++++++++
 tb/tb_updn_counter.sv | 196 +++++++++++++++++++
 4 files changed

// File: rtl/updn_counter_pkg.sv
// Shared types for the up/down counter: step direction and next-value result.
package updn_counter_pkg;

    // Wide enough for any supported WIDTH (<= 32) plus the carry bit.
    localparam int UPDN_VAL_W = 33;

    typedef enum logic [1:0] {
        HOLD = 2'd0,
        UP   = 2'd1,
        DOWN = 2'd2,
        LOAD = 2'd3
    } dir_e;

    typedef struct packed {
        logic [UPDN_VAL_W-1:0] value;
        logic                  ovf;
        logic                  unf;
    } next_t;

endpackage

// File: rtl/updn_counter_next.sv
// Combinational next-count and boundary-crossing decode for updn_counter.
// Saturation support is compiled in only when UPDN_COUNTER_SAT_EN is defined.
module updn_counter_next
    import updn_counter_pkg::*;
#(
    parameter int WIDTH   = 4,
    parameter int MAX_VAL = 2**WIDTH - 1,
    parameter int STEP    = 1
) (
    input  logic [WIDTH-1:0] count,
    input  logic             increment,
    input  logic             decrement,
    input  logic             load,
    input  logic [WIDTH-1:0] load_val,
`ifdef UPDN_COUNTER_SAT_EN
    input  logic             sat_mode,
`endif
    output next_t            result
);

    // One extra bit so sums and wrap corrections never truncate.
    localparam logic [WIDTH:0] MAX_W  = (WIDTH+1)'(MAX_VAL);
    localparam logic [WIDTH:0] STEP_W = (WIDTH+1)'(STEP);
    localparam logic [WIDTH:0] MOD_W  = MAX_W + {{WIDTH{1'b0}}, 1'b1};

    dir_e           dir_s;
    logic [WIDTH:0] cur_s;
    logic [WIDTH:0] ld_s;
    logic [WIDTH:0] sum_s;
    logic [WIDTH:0] nxt_s;
    logic           ovf_s;
    logic           unf_s;

    assign cur_s = {1'b0, count};
    assign ld_s  = {1'b0, load_val};
    assign sum_s = cur_s + STEP_W;

    // Request priority: load, then exactly one of increment/decrement.
    always_comb begin
        dir_s = HOLD;
        if (load) begin
            dir_s = LOAD;
        end else if (increment ^ decrement) begin
            if (increment) begin
                dir_s = UP;
            end else begin
                dir_s = DOWN;
            end
        end else begin
            dir_s = HOLD;
        end
    end

    // Next value and crossing flags for the selected direction.
    always_comb begin
        nxt_s = cur_s;
        ovf_s = 1'b0;
        unf_s = 1'b0;
        case (dir_s)
            LOAD: begin
                if (ld_s > MAX_W) begin
                    nxt_s = MAX_W;
                end else begin
                    nxt_s = ld_s;
                end
            end
            UP: begin
                if (sum_s > MAX_W) begin
                    ovf_s = 1'b1;
`ifdef UPDN_COUNTER_SAT_EN
                    if (sat_mode) begin
                        nxt_s = MAX_W;
                    end else begin
                        nxt_s = sum_s - MOD_W;
                    end
`else
                    nxt_s = sum_s - MOD_W;
`endif
                end else begin
                    nxt_s = sum_s;
                end
            end
            DOWN: begin
                if (cur_s >= STEP_W) begin
                    nxt_s = cur_s - STEP_W;
                end else begin
                    unf_s = 1'b1;
`ifdef UPDN_COUNTER_SAT_EN
                    if (sat_mode) begin
                        nxt_s = {(WIDTH+1){1'b0}};
                    end else begin
                        nxt_s = (cur_s + MOD_W) - STEP_W;
                    end
`else
                    nxt_s = (cur_s + MOD_W) - STEP_W;
`endif
                end
            end
            default: begin
                nxt_s = cur_s;
            end
        endcase
    end

    // Pack into the shared result type, zero-extending the value.
    always_comb begin
        result              = '{value: {UPDN_VAL_W{1'b0}}, ovf: 1'b0, unf: 1'b0};
        result.value[WIDTH:0] = nxt_s;
        result.ovf          = ovf_s;
        result.unf          = unf_s;
    end

endmodule

// File: rtl/updn_counter.sv
// Up/down counter with wrap (and optional saturate) modes and boundary flags.
// Define UPDN_COUNTER_SAT_EN to add the sat_mode input and saturation logic.
module updn_counter
    import updn_counter_pkg::*;
#(
    parameter int WIDTH   = 4,
    parameter int MAX_VAL = 2**WIDTH - 1,
    parameter int STEP    = 1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             increment,
    input  logic             decrement,
    input  logic             load,
    input  logic [WIDTH-1:0] load_val,
`ifdef UPDN_COUNTER_SAT_EN
    input  logic             sat_mode,
`endif
    input  logic             clr_flags,
    output logic [WIDTH-1:0] count,
    output logic             at_max,
    output logic             at_zero,
    output logic             ovf_pulse,
    output logic             unf_pulse,
    output logic             ovf_sticky,
    output logic             unf_sticky
);

    localparam logic [WIDTH-1:0] MAX_C = WIDTH'(MAX_VAL);

    next_t            nxt_s;
    logic             nxt_unused_s;
    logic [WIDTH-1:0] count_r;
    logic             ovf_pulse_r;
    logic             unf_pulse_r;
    logic             ovf_sticky_r;
    logic             unf_sticky_r;

    updn_counter_next #(
        .WIDTH   (WIDTH),
        .MAX_VAL (MAX_VAL),
        .STEP    (STEP)
    ) u_next (
        .count     (count_r),
        .increment (increment),
        .decrement (decrement),
        .load      (load),
        .load_val  (load_val),
`ifdef UPDN_COUNTER_SAT_EN
        .sat_mode  (sat_mode),
`endif
        .result    (nxt_s)
    );

    // The next value never exceeds MAX_VAL, so the upper bits are always zero.
    assign nxt_unused_s = |nxt_s.value[UPDN_VAL_W-1:WIDTH];

    // Count, pulse and sticky-flag registers; a set wins over clr_flags.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            count_r      <= {WIDTH{1'b0}};
            ovf_pulse_r  <= 1'b0;
            unf_pulse_r  <= 1'b0;
            ovf_sticky_r <= 1'b0;
            unf_sticky_r <= 1'b0;
        end else begin
            count_r      <= nxt_s.value[WIDTH-1:0];
            ovf_pulse_r  <= nxt_s.ovf;
            unf_pulse_r  <= nxt_s.unf;
            ovf_sticky_r <= nxt_s.ovf | (ovf_sticky_r & ~clr_flags);
            unf_sticky_r <= nxt_s.unf | (unf_sticky_r & ~clr_flags);
        end
    end

    assign count      = count_r;
    assign at_max     = (count_r == MAX_C);
    assign at_zero    = (count_r == {WIDTH{1'b0}});
    assign ovf_pulse  = ovf_pulse_r;
    assign unf_pulse  = unf_pulse_r;
    assign ovf_sticky = ovf_sticky_r;
    assign unf_sticky = unf_sticky_r;

endmodule

// File: tb/tb_updn_counter.sv
// Directed self-checking bench for updn_counter (WIDTH=4, MAX_VAL=9, STEP=3
// plus a WIDTH=4, MAX_VAL=15, STEP=1 instance); saturation cases need UPDN_COUNTER_SAT_EN.
module tb_updn_counter;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       increment = 1'b0;
    logic       decrement = 1'b0;
    logic       load = 1'b0;
    logic [3:0] load_val = 4'd0;
    logic       sat_mode = 1'b0;
    logic       clr_flags = 1'b0;
    logic [3:0] count;
    logic       at_max, at_zero, ovf_pulse, unf_pulse, ovf_sticky, unf_sticky;

    logic       inc_b = 1'b0;
    logic [3:0] count_b;
    logic       at_max_b, at_zero_b, ovf_pulse_b, unf_pulse_b, ovf_sticky_b, unf_sticky_b;

    int total = 0;
    int bad   = 0;
    int ovf_seen;

    always #5 clk = ~clk;

    updn_counter #(.WIDTH(4), .MAX_VAL(9), .STEP(3)) dut (
        .clk(clk), .reset(reset), .increment(increment), .decrement(decrement),
        .load(load), .load_val(load_val),
`ifdef UPDN_COUNTER_SAT_EN
        .sat_mode(sat_mode),
`endif
        .clr_flags(clr_flags), .count(count), .at_max(at_max), .at_zero(at_zero),
        .ovf_pulse(ovf_pulse), .unf_pulse(unf_pulse),
        .ovf_sticky(ovf_sticky), .unf_sticky(unf_sticky)
    );

    updn_counter #(.WIDTH(4), .MAX_VAL(15), .STEP(1)) dut_b (
        .clk(clk), .reset(reset), .increment(inc_b), .decrement(1'b0),
        .load(1'b0), .load_val(4'd0),
`ifdef UPDN_COUNTER_SAT_EN
        .sat_mode(1'b0),
`endif
        .clr_flags(1'b0), .count(count_b), .at_max(at_max_b), .at_zero(at_zero_b),
        .ovf_pulse(ovf_pulse_b), .unf_pulse(unf_pulse_b),
        .ovf_sticky(ovf_sticky_b), .unf_sticky(unf_sticky_b)
    );

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%0d expected=%0d", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check_state(input string tag, input logic [3:0] c,
                               input logic op, input logic up, input logic os, input logic us);
        check_val({tag, ".count"}, 32'(count), 32'(c));
        check_val({tag, ".ovf_pulse"}, 32'(ovf_pulse), 32'(op));
        check_val({tag, ".unf_pulse"}, 32'(unf_pulse), 32'(up));
        check_val({tag, ".ovf_sticky"}, 32'(ovf_sticky), 32'(os));
        check_val({tag, ".unf_sticky"}, 32'(unf_sticky), 32'(us));
    endtask

    initial begin
        #1;
        check_state("reset_async", 4'd0, 1'b0, 1'b0, 1'b0, 1'b0);
        tick();
        tick();
        @(negedge clk);
        reset = 1'b0;
        tick();
        check_state("reset", 4'd0, 1'b0, 1'b0, 1'b0, 1'b0);
        check_val("reset.at_zero", 32'(at_zero), 32'd1);
        check_val("reset.at_max", 32'(at_max), 32'd0);

        // load 8, then increment wraps 8+3-10 = 1
        load = 1'b1; load_val = 4'd8;
        tick();
        check_state("load8", 4'd8, 1'b0, 1'b0, 1'b0, 1'b0);
        load = 1'b0; increment = 1'b1;
        tick();
        check_state("wrap_up", 4'd1, 1'b1, 1'b0, 1'b1, 1'b0);
        increment = 1'b0;
        tick();
        check_state("wrap_up_after", 4'd1, 1'b0, 1'b0, 1'b1, 1'b0);

        // decrement from 1 wraps to 1+10-3 = 8
        decrement = 1'b1;
        tick();
        check_state("wrap_dn", 4'd8, 1'b0, 1'b1, 1'b1, 1'b1);
        decrement = 1'b0;
        tick();
        check_state("wrap_dn_after", 4'd8, 1'b0, 1'b0, 1'b1, 1'b1);

        // clr_flags together with a new overflow: ovf stays set, unf clears
        increment = 1'b1; clr_flags = 1'b1;
        tick();
        check_state("clr_vs_set", 4'd1, 1'b1, 1'b0, 1'b1, 1'b0);
        increment = 1'b0;
        tick();
        check_state("clr", 4'd1, 1'b0, 1'b0, 1'b0, 1'b0);
        clr_flags = 1'b0;

        // both requests: hold
        increment = 1'b1; decrement = 1'b1;
        tick();
        check_state("both_hold", 4'd1, 1'b0, 1'b0, 1'b0, 1'b0);

        // load beats step and clamps to MAX_VAL
        load = 1'b1; load_val = 4'd15; decrement = 1'b0;
        tick();
        check_state("load_clamp", 4'd9, 1'b0, 1'b0, 1'b0, 1'b0);
        check_val("load_clamp.at_max", 32'(at_max), 32'd1);
        load = 1'b0; decrement = 1'b1;
        tick();
        check_state("max_both_hold", 4'd9, 1'b0, 1'b0, 1'b0, 1'b0);
        increment = 1'b0;
        tick();
        check_state("dn_from_9", 4'd6, 1'b0, 1'b0, 1'b0, 1'b0);
        decrement = 1'b0;

        // load 0 then decrement wraps to 0+10-3 = 7
        load = 1'b1; load_val = 4'd0;
        tick();
        check_val("load0.at_zero", 32'(at_zero), 32'd1);
        load = 1'b0; decrement = 1'b1;
        tick();
        check_state("wrap_dn0", 4'd7, 1'b0, 1'b1, 1'b0, 1'b1);
        decrement = 1'b0;

        // asynchronous reset mid-operation at count=6
        load = 1'b1; load_val = 4'd6;
        tick();
        check_state("pre_rst", 4'd6, 1'b0, 1'b0, 1'b0, 1'b1);
        load = 1'b0; increment = 1'b1;
        #2;
        reset = 1'b1;
        #1;
        check_state("rst_mid", 4'd0, 1'b0, 1'b0, 1'b0, 1'b0);
        load = 1'b1; load_val = 4'd5; increment = 1'b0;
        tick();
        check_state("rst_hold", 4'd0, 1'b0, 1'b0, 1'b0, 1'b0);
        @(negedge clk);
        reset = 1'b0; load = 1'b0; increment = 1'b1;
        tick();
        check_state("rst_release", 4'd3, 1'b0, 1'b0, 1'b0, 1'b0);
        increment = 1'b0;

`ifdef UPDN_COUNTER_SAT_EN
        // saturate: 8 + 3 x3 -> held at 9, ovf pulse every requested cycle
        sat_mode = 1'b1; clr_flags = 1'b1;
        load = 1'b1; load_val = 4'd8;
        tick();
        clr_flags = 1'b0; load = 1'b0; increment = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick();
            check_state($sformatf("sat_up%0d", i), 4'd9, 1'b1, 1'b0, 1'b1, 1'b0);
        end
        increment = 1'b0;
        tick();
        check_state("sat_up_end", 4'd9, 1'b0, 1'b0, 1'b1, 1'b0);
        load = 1'b1; load_val = 4'd1;
        tick();
        load = 1'b0; decrement = 1'b1;
        tick();
        check_state("sat_dn", 4'd0, 1'b0, 1'b1, 1'b1, 1'b1);
        decrement = 1'b0; sat_mode = 1'b0;
`endif

        // STEP=1, MAX_VAL=15: 16 increments return to 0 with one overflow
        reset = 1'b1;
        tick();
        @(negedge clk);
        reset = 1'b0;
        ovf_seen = 0;
        inc_b = 1'b1;
        for (int i = 0; i < 16; i++) begin
            tick();
            if (ovf_pulse_b) ovf_seen++;
        end
        inc_b = 1'b0;
        check_val("b16.count", 32'(count_b), 32'd0);
        check_val("b16.ovf_count", 32'(ovf_seen), 32'd1);
        check_val("b16.ovf_sticky", 32'(ovf_sticky_b), 32'd1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
